// File: rtl/fft_frame_engine.sv
// rtl/fft_frame_engine.sv - windowed ADC frame capture feeding an AXI-Stream FFT core with streamed |re|+|im| magnitudes
//
// Captures DISCARD+N+TAIL samples and keeps the middle N. It sends one forward
// config word, streams the kept frame to the core, then drains the N output
// beats. Each bin is reported as |re|+|im| while tracking the peak bin.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enable, continuous        run request, auto re-arm after each frame
//   adc_data, adc_valid       sample input, accepted only while ready_for_data=1
//   ready_for_data            high while sampling
//   cfg_t*                    FFT config channel (constant forward config)
//   s_t*                      FFT input stream, {imag=0, real=sample}
//   m_t*                      FFT output stream, {imag, real}
//   real_part .. mag_valid    per-bin result, one cycle after each output beat
//   peak_bin, peak_mag        running peak of the current frame
//   frame_done, frame_count   end-of-frame pulse and wrapping frame counter
//   tlast_err                 sticky m_tlast/beat-count disagreement for this frame
//   busy                      high in any state except IDLE
module fft_frame_engine #(
  parameter int LOG2_N  = 11,
  parameter int IN_W    = 16,
  parameter int OUT_W   = 27,
  parameter int DISCARD = 200,
  parameter int TAIL    = 152,
  parameter int SKIP_DC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  continuous,
  input  logic [IN_W-1:0]       adc_data,
  input  logic                  adc_valid,
  output logic                  ready_for_data,
  output logic [15:0]           cfg_tdata,
  output logic                  cfg_tvalid,
  input  logic                  cfg_tready,
  output logic [2*IN_W-1:0]     s_tdata,
  output logic                  s_tvalid,
  input  logic                  s_tready,
  output logic                  s_tlast,
  input  logic [2*OUT_W-1:0]    m_tdata,
  input  logic                  m_tvalid,
  output logic                  m_tready,
  input  logic                  m_tlast,
  output logic [OUT_W-1:0]      real_part,
  output logic [OUT_W-1:0]      imag_part,
  output logic [OUT_W:0]        magnitude,
  output logic [LOG2_N-1:0]     bin_index,
  output logic                  mag_valid,
  output logic [LOG2_N-1:0]     peak_bin,
  output logic [OUT_W:0]        peak_mag,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic                  tlast_err,
  output logic                  busy
);

  localparam int N     = 1 << LOG2_N;
  localparam int TOTAL = DISCARD + N + TAIL;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0]  DISC_LO  = CNT_W'(DISCARD);
  localparam logic [CNT_W-1:0]  DISC_HI  = CNT_W'(DISCARD + N);
  localparam logic [CNT_W-1:0]  LAST_SMP = CNT_W'(TOTAL - 1);
  localparam logic [LOG2_N-1:0] LAST_IDX = LOG2_N'(N - 1);

  typedef enum logic [2:0] {IDLE, SAMPLE, CONFIG, FEED, DRAIN, DONE} state_t;
  state_t state, next_state;

  logic [IN_W-1:0]   sample_mem [N];
  logic [CNT_W-1:0]  smp_cnt;
  logic [LOG2_N-1:0] wr_addr;
  logic [LOG2_N-1:0] feed_idx;
  logic [IN_W-1:0]   feed_data;
  logic              feed_valid;
  logic [LOG2_N-1:0] beat_idx;
  logic              sample_take, cfg_fire, feed_fire, beat_take, last_beat;
  logic              peak_clear, peak_ok;
  logic [OUT_W-1:0]  beat_re, beat_im;
  logic [OUT_W:0]    abs_re, abs_im, beat_mag;

  assign sample_take = (state == SAMPLE) && adc_valid;
  assign cfg_fire    = (state == CONFIG) && cfg_tready;
  assign feed_fire   = (state == FEED) && feed_valid && s_tready;
  assign beat_take   = (state == DRAIN) && m_tvalid;
  assign last_beat   = (beat_idx == LAST_IDX);
  assign wr_addr     = LOG2_N'(smp_cnt - DISC_LO);

  // One extra bit so |-2^(OUT_W-1)| and the sum of two such values fit exactly.
  assign beat_re  = m_tdata[OUT_W-1:0];
  assign beat_im  = m_tdata[2*OUT_W-1:OUT_W];
  assign abs_re   = beat_re[OUT_W-1] ? -{1'b1, beat_re} : {1'b0, beat_re};
  assign abs_im   = beat_im[OUT_W-1] ? -{1'b1, beat_im} : {1'b0, beat_im};
  assign beat_mag = abs_re + abs_im;
  // Strict compare keeps the lower bin on ties.
  assign peak_ok  = !((SKIP_DC != 0) && (beat_idx == '0)) && (beat_mag > peak_mag);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state     = state;
    ready_for_data = 1'b0;
    cfg_tvalid     = 1'b0;
    m_tready       = 1'b0;
    busy           = (state != IDLE);
    cfg_tdata      = 16'h0001;
    s_tvalid       = feed_valid;
    s_tdata        = {{IN_W{1'b0}}, feed_data};
    s_tlast        = feed_valid && (feed_idx == LAST_IDX);
    case (state)
      IDLE:   if (enable) next_state = SAMPLE;
      SAMPLE: begin
        ready_for_data = 1'b1;
        if (!enable) next_state = IDLE;
        else if (sample_take && (smp_cnt == LAST_SMP)) next_state = CONFIG;
      end
      CONFIG: begin
        cfg_tvalid = 1'b1;
        if (cfg_tready) next_state = FEED;
      end
      FEED:   if (feed_fire && (feed_idx == LAST_IDX)) next_state = DRAIN;
      DRAIN: begin
        m_tready = 1'b1;
        if (beat_take && last_beat) next_state = DONE;
      end
      DONE: begin
        if (enable && continuous) next_state = SAMPLE;
        else if (!enable)         next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Peak and tlast status restart whenever a new frame can begin.
  assign peak_clear = (state == IDLE) || ((state == DONE) && (next_state == SAMPLE));

  always_ff @(posedge clk) begin
    if (sample_take && (smp_cnt >= DISC_LO) && (smp_cnt < DISC_HI))
      sample_mem[wr_addr] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt     <= '0;
      feed_idx    <= '0;
      feed_data   <= '0;
      feed_valid  <= 1'b0;
      beat_idx    <= '0;
      real_part   <= '0;
      imag_part   <= '0;
      magnitude   <= '0;
      bin_index   <= '0;
      mag_valid   <= 1'b0;
      peak_bin    <= '0;
      peak_mag    <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      tlast_err   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      mag_valid  <= 1'b0;

      if (state != SAMPLE)  smp_cnt <= '0;
      else if (sample_take) smp_cnt <= smp_cnt + CNT_W'(1);

      // Output register always holds the element on offer; the next one is
      // loaded on the handshake, so a held-high s_tready gives one beat per cycle.
      if (cfg_fire) begin
        feed_valid <= 1'b1;
        feed_idx   <= '0;
        feed_data  <= sample_mem[0];
      end else if (feed_fire) begin
        if (feed_idx == LAST_IDX) begin
          feed_valid <= 1'b0;
        end else begin
          feed_idx  <= feed_idx + LOG2_N'(1);
          feed_data <= sample_mem[feed_idx + LOG2_N'(1)];
        end
      end

      if (state != DRAIN) beat_idx <= '0;
      if (beat_take) begin
        beat_idx  <= beat_idx + LOG2_N'(1);
        real_part <= beat_re;
        imag_part <= beat_im;
        magnitude <= beat_mag;
        bin_index <= beat_idx;
        mag_valid <= 1'b1;
        if (m_tlast != last_beat) tlast_err <= 1'b1;
        if (peak_ok) begin
          peak_mag <= beat_mag;
          peak_bin <= beat_idx;
        end
        if (last_beat) begin
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
        end
      end

      if (peak_clear) begin
        peak_mag  <= '0;
        peak_bin  <= '0;
        tlast_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_engine.sv
// tb/tb_fft_frame_engine.sv - directed self-checking bench for fft_frame_engine (N=8, DISCARD=2, TAIL=1)
module tb_fft_frame_engine;

  localparam int LOG2_N = 3;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 27;

  logic                 clk = 1'b0;
  logic                 rst, enable, continuous, adc_valid;
  logic [IN_W-1:0]      adc_data;
  logic                 ready_for_data;
  logic [15:0]          cfg_tdata;
  logic                 cfg_tvalid, cfg_tready;
  logic [2*IN_W-1:0]    s_tdata;
  logic                 s_tvalid, s_tready, s_tlast;
  logic [2*OUT_W-1:0]   m_tdata;
  logic                 m_tvalid, m_tready, m_tlast;
  logic [OUT_W-1:0]     real_part, imag_part;
  logic [OUT_W:0]       magnitude, peak_mag;
  logic [LOG2_N-1:0]    bin_index, peak_bin;
  logic                 mag_valid, frame_done, tlast_err, busy;
  logic [15:0]          frame_count;

  int passed = 0;
  int total  = 0;

  int     re_v [8];
  int     im_v [8];
  bit     tl_v [8];
  longint mag_v [8];
  int     pbin_v [8];
  longint pmag_v [8];
  bit     terr_v [8];
  bit     pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  fft_frame_engine #(
    .LOG2_N(LOG2_N), .IN_W(IN_W), .OUT_W(OUT_W), .DISCARD(2), .TAIL(1), .SKIP_DC(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .continuous(continuous),
    .adc_data(adc_data), .adc_valid(adc_valid), .ready_for_data(ready_for_data),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .real_part(real_part), .imag_part(imag_part), .magnitude(magnitude),
    .bin_index(bin_index), .mag_valid(mag_valid), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .frame_done(frame_done), .frame_count(frame_count),
    .tlast_err(tlast_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic capture_and_config(input int base);
    for (int i = 0; i < 11; i++) begin
      check("ready_for_data_hi", ready_for_data, 1);
      adc_data  = 16'(base + i);
      adc_valid = 1'b1;
      tick;
    end
    adc_valid = 1'b0;
    check("ready_for_data_lo", ready_for_data, 0);
    check("cfg_tvalid_hi", cfg_tvalid, 1);
    check("s_tvalid_before_cfg", s_tvalid, 0);
    tick;
    check("cfg_tvalid_held", cfg_tvalid, 1);
    check("cfg_tdata", cfg_tdata, 16'h0001);
    check("s_tvalid_cfg_stall", s_tvalid, 0);
    cfg_tready = 1'b1;
    tick;
    cfg_tready = 1'b0;
    check("cfg_tvalid_lo", cfg_tvalid, 0);
  endtask

  task automatic feed(input int first, input bit bp);
    int  sent = 0;
    int  cyc  = 0;
    bit  rdy;
    check("s_tdata_imag_zero", s_tdata[31:16], 0);
    while (sent < 8 && cyc < 64) begin
      rdy      = bp ? pat[cyc % 6] : 1'b1;
      s_tready = rdy;
      check("s_tvalid_feed", s_tvalid, 1);
      check("s_tdata_real", s_tdata[15:0], 64'(first + sent));
      check("s_tlast", s_tlast, sent == 7);
      tick;
      if (rdy) sent++;
      cyc++;
    end
    s_tready = 1'b0;
    check("feed_count", sent, 8);
    check("s_tvalid_after_feed", s_tvalid, 0);
  endtask

  task automatic drain;
    for (int k = 0; k < 8; k++) begin
      check("m_tready_drain", m_tready, 1);
      m_tvalid = 1'b1;
      m_tdata  = {im_v[k][26:0], re_v[k][26:0]};
      m_tlast  = tl_v[k];
      tick;
      check("mag_valid", mag_valid, 1);
      check("bin_index", bin_index, k);
      check("real_part", real_part, re_v[k][26:0]);
      check("imag_part", imag_part, im_v[k][26:0]);
      check("magnitude", magnitude, mag_v[k]);
      check("peak_bin", peak_bin, pbin_v[k]);
      check("peak_mag", peak_mag, pmag_v[k]);
      check("tlast_err", tlast_err, terr_v[k]);
      check("frame_done_timing", frame_done, k == 7);
    end
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    check("m_tready_after_drain", m_tready, 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; continuous = 1'b0; adc_valid = 1'b0; adc_data = '0;
    cfg_tready = 1'b0; s_tready = 1'b0; m_tvalid = 1'b0; m_tlast = 1'b0; m_tdata = '0;
    tick; tick; tick;

    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_cfg_tdata", cfg_tdata, 16'h0001);
    check("rst_s_tvalid", s_tvalid, 0);
    check("rst_ready", ready_for_data, 0);
    check("rst_peak_mag", peak_mag, 0);

    // Frame 1: ramp 0..10, no backpressure, clean tlast, stay in DONE while enable=1.
    rst = 1'b0; enable = 1'b1;
    tick;
    check("sample_busy", busy, 1);
    capture_and_config(0);
    feed(2, 1'b0);
    re_v   = '{0, -5, 7, -67108864, 4, 100, -1, 0};
    im_v   = '{0, 3, -1, -67108864, 4, -200, 0, 0};
    tl_v   = '{0, 0, 0, 0, 0, 0, 0, 1};
    mag_v  = '{0, 8, 8, 134217728, 8, 300, 1, 0};
    pbin_v = '{0, 1, 1, 3, 3, 3, 3, 3};
    pmag_v = '{0, 8, 8, 134217728, 134217728, 134217728, 134217728, 134217728};
    terr_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    drain;
    check("f1_frame_count", frame_count, 1);
    tick;
    check("f1_frame_done_pulse", frame_done, 0);
    check("f1_mag_valid_drop", mag_valid, 0);
    check("f1_done_wait_busy", busy, 1);
    check("f1_peak_hold", peak_bin, 3);
    tick;
    check("f1_done_still", busy, 1);
    enable = 1'b0;
    tick;
    check("f1_idle", busy, 0);
    tick;
    check("idle_peak_mag_clr", peak_mag, 0);
    check("idle_peak_bin_clr", peak_bin, 0);
    check("idle_frame_count_hold", frame_count, 1);

    // Frame 2: backpressure, DC ignored, tlast errors; continuous re-arm.
    continuous = 1'b1; enable = 1'b1;
    tick;
    capture_and_config(20);
    feed(22, 1'b1);
    re_v   = '{-67108864, 3, 0, 1, -10, 0, 5, 2};
    im_v   = '{-67108864, 0, -3, 1, 0, 0, 5, 2};
    tl_v   = '{0, 0, 0, 0, 0, 1, 0, 0};
    mag_v  = '{134217728, 3, 3, 2, 10, 0, 10, 4};
    pbin_v = '{0, 1, 1, 1, 4, 4, 4, 4};
    pmag_v = '{0, 3, 3, 3, 10, 10, 10, 10};
    terr_v = '{0, 0, 0, 0, 0, 1, 1, 1};
    drain;
    check("f2_frame_count", frame_count, 2);
    tick;
    check("f2_rearm_sampling", ready_for_data, 1);
    check("f2_tlast_err_clr", tlast_err, 0);
    check("f2_peak_clr", peak_mag, 0);
    check("f2_frame_done_pulse", frame_done, 0);

    // Frame 3: back-to-back, discard applied again; enable dropped during drain.
    capture_and_config(40);
    feed(42, 1'b0);
    continuous = 1'b0; enable = 1'b0;
    re_v   = '{0, 1, 2, 3, 4, 5, 6, 7};
    im_v   = '{0, 0, 0, 0, 0, 0, 0, 0};
    tl_v   = '{0, 0, 0, 0, 0, 0, 0, 1};
    mag_v  = '{0, 1, 2, 3, 4, 5, 6, 7};
    pbin_v = '{0, 1, 2, 3, 4, 5, 6, 7};
    pmag_v = '{0, 1, 2, 3, 4, 5, 6, 7};
    terr_v = '{0, 0, 0, 0, 0, 0, 0, 0};
    drain;
    check("f3_frame_count", frame_count, 3);
    tick;
    check("f3_to_idle", busy, 0);

    // Abort mid-SAMPLE: no frame_done, count unchanged.
    enable = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      adc_data = 16'(80 + i); adc_valid = 1'b1;
      tick;
    end
    enable = 1'b0; adc_valid = 1'b0;
    tick;
    check("abort_idle", busy, 0);
    check("abort_ready", ready_for_data, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_no_done", frame_done, 0);
      tick;
    end
    check("abort_frame_count", frame_count, 3);

    // Reset mid-FEED.
    enable = 1'b1;
    tick;
    capture_and_config(60);
    s_tready = 1'b1;
    tick; tick;
    check("feed_mid_data", s_tdata[15:0], 64);
    rst = 1'b1;
    tick;
    rst = 1'b0; s_tready = 1'b0; enable = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_s_tvalid", s_tvalid, 0);
    check("rstmid_s_tdata", s_tdata, 0);
    check("rstmid_frame_count", frame_count, 0);
    check("rstmid_cfg_tdata", cfg_tdata, 16'h0001);
    check("rstmid_real_part", real_part, 0);
    check("rstmid_magnitude", magnitude, 0);
    check("rstmid_bin_index", bin_index, 0);
    check("rstmid_peak_bin", peak_bin, 0);
    check("rstmid_m_tready", m_tready, 0);
    check("rstmid_mag_valid", mag_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
